mem_seq_ctrl: RTL and testbench

- Multicycle sequencer for the combinational MIPS core datapath.
- Holds the architectural PC and instruction registers and owns the single shared memory port.
- Serialises instruction fetch and data load/store over that port with a req/gnt/rvalid handshake, then commits the register-file write and PC update once per instruction.

---
 rtl/mem_seq_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_mem_seq_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_seq_ctrl.sv
// Multicycle sequencer for the combinational MIPS core: owns PC/IR and the single
// shared memory port, serialising fetch, load and store, and commits once per instruction.
module mem_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        coreRdEn,
  input  logic [31:0] coreRdAddr,
  input  logic        coreWrEn,
  input  logic [31:0] coreWrAddr,
  input  logic [31:0] coreWrData,
  input  logic        coreRegWr,
  input  logic [31:0] corePcNxt,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [31:0] coreMemRdData,
  output logic        regWrEn,
  output logic        retire,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  input  logic        memGnt,
  input  logic        memRvalid,
  input  logic [31:0] memRdata,
  output logic        errTimeout,
  output logic        errAlign,
  output logic        halted
);

  typedef enum logic [2:0] {
    FETCH, FWAIT, EXEC, DREQ, DWAIT, COMMIT, HALT
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state, state_nxt;
  logic [31:0] pc_nxt_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        we_q;
  logic [7:0]  wait_cnt;

  logic        waiting;
  logic        pc_ld;
  logic [31:0] pc_val;
  logic        instr_ld;
  logic        rdata_ld;
  logic        op_ld;
  logic        set_align;
  logic        set_timeout;

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    memReq      = 1'b0;
    memWe       = 1'b0;
    memAddr     = '0;
    memWdata    = '0;
    regWrEn     = 1'b0;
    retire      = 1'b0;
    waiting     = 1'b0;
    pc_ld       = 1'b0;
    pc_val      = pc_nxt_q;
    instr_ld    = 1'b0;
    rdata_ld    = 1'b0;
    op_ld       = 1'b0;
    set_align   = 1'b0;
    set_timeout = 1'b0;

    unique case (state)
      FETCH: begin
        if (run && !rst) begin
          if (pc[1:0] != 2'b00) begin
            state_nxt = HALT;
            set_align = 1'b1;
          end else begin
            memReq  = 1'b1;
            memAddr = pc;
            waiting = 1'b1;
            if (memGnt) state_nxt = FWAIT;
          end
        end
      end

      FWAIT: begin
        waiting = 1'b1;
        if (memRvalid) begin
          instr_ld  = 1'b1;
          state_nxt = EXEC;
        end
      end

      EXEC: begin
        op_ld = 1'b1;
        if (coreRdEn && coreWrEn) begin
          state_nxt = HALT;
          set_align = 1'b1;
        end else if (coreRdEn) begin
          if (coreRdAddr[1:0] != 2'b00) begin
            state_nxt = HALT;
            set_align = 1'b1;
          end else begin
            state_nxt = DREQ;
          end
        end else if (coreWrEn) begin
          if (coreWrAddr[1:0] != 2'b00) begin
            state_nxt = HALT;
            set_align = 1'b1;
          end else begin
            state_nxt = DREQ;
          end
        end else begin
          // No memory phase: commit straight from the core's combinational outputs.
          regWrEn   = coreRegWr;
          retire    = 1'b1;
          pc_ld     = 1'b1;
          pc_val    = corePcNxt;
          state_nxt = FETCH;
        end
      end

      DREQ: begin
        memReq   = 1'b1;
        memWe    = we_q;
        memAddr  = addr_q;
        memWdata = data_q;
        waiting  = 1'b1;
        if (memGnt) begin
          if (we_q) begin
            retire    = 1'b1;
            pc_ld     = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = DWAIT;
          end
        end
      end

      DWAIT: begin
        waiting = 1'b1;
        if (memRvalid) begin
          rdata_ld  = 1'b1;
          state_nxt = COMMIT;
        end
      end

      COMMIT: begin
        regWrEn   = coreRegWr;
        retire    = 1'b1;
        pc_ld     = 1'b1;
        state_nxt = FETCH;
      end

      HALT: begin
        state_nxt = HALT;
      end

      default: begin
        state_nxt = HALT;
      end
    endcase

    // A wait state that makes no progress for MAX_WAIT cycles abandons the access.
    if (waiting && (state_nxt == state) && (wait_cnt == WAIT_LAST)) begin
      state_nxt   = HALT;
      set_timeout = 1'b1;
    end
  end

  assign halted = (state == HALT);

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      instr         <= '0;
      coreMemRdData <= '0;
      pc_nxt_q      <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      we_q          <= 1'b0;
      wait_cnt      <= '0;
      errTimeout    <= 1'b0;
      errAlign      <= 1'b0;
    end else begin
      state <= state_nxt;

      if ((state_nxt != state) || !waiting) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      if (pc_ld)    pc            <= pc_val;
      if (instr_ld) instr         <= memRdata;
      if (rdata_ld) coreMemRdData <= memRdata;

      if (op_ld) begin
        pc_nxt_q <= corePcNxt;
        we_q     <= coreWrEn;
        addr_q   <= coreWrEn ? coreWrAddr : coreRdAddr;
        data_q   <= coreWrEn ? coreWrData : 32'h0;
      end

      if (set_align)   errAlign   <= 1'b1;
      if (set_timeout) errTimeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Self-checking bench for mem_seq_ctrl: a memory responder with programmable delays,
// a toy decoder standing in for the core, directed vectors and a random instruction stream.
module tb_mem_seq_ctrl;

  localparam int          MAX_WAIT = 255;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        coreRdEn = 1'b0, coreWrEn = 1'b0, coreRegWr = 1'b0;
  logic [31:0] coreRdAddr = '0, coreWrAddr = '0, coreWrData = '0, corePcNxt = '0;
  logic [31:0] pc, instr, coreMemRdData, memAddr, memWdata;
  logic        regWrEn, retire, memReq, memWe, errTimeout, errAlign, halted;
  logic        memGnt = 1'b0, memRvalid = 1'b0;
  logic [31:0] memRdata = '0;

  mem_seq_ctrl #(.RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .run(run),
    .coreRdEn(coreRdEn), .coreRdAddr(coreRdAddr),
    .coreWrEn(coreWrEn), .coreWrAddr(coreWrAddr), .coreWrData(coreWrData),
    .coreRegWr(coreRegWr), .corePcNxt(corePcNxt),
    .pc(pc), .instr(instr), .coreMemRdData(coreMemRdData),
    .regWrEn(regWrEn), .retire(retire),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memGnt(memGnt), .memRvalid(memRvalid), .memRdata(memRdata),
    .errTimeout(errTimeout), .errAlign(errAlign), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Toy core: op in [1:0] (0 alu, 1 load, 2 store, 3 branch), regwr in [2],
  // word index in [11:4], store byte in [31:24], branch word target in [19:12].
  typedef struct packed {
    logic        rd;
    logic        wr;
    logic        regwr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pcnxt;
  } core_t;

  bit          inj_misalign = 1'b0;
  bit          inj_both     = 1'b0;
  logic [31:0] inj_pc_off   = '0;

  function automatic core_t decode(input logic [31:0] ins, input logic [31:0] p);
    core_t c;
    c.rd    = (ins[1:0] == 2'd1);
    c.wr    = (ins[1:0] == 2'd2) || (c.rd && inj_both);
    c.regwr = ins[2];
    c.addr  = {22'h0, ins[11:4], 2'b00} | (inj_misalign ? 32'd2 : 32'd0);
    c.wdata = {24'h0, ins[31:24]};
    c.pcnxt = ((ins[1:0] == 2'd3) ? {22'h0, ins[19:12], 2'b00} : p + 32'd4) + inj_pc_off;
    return c;
  endfunction

  // Memory responder state.
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  int          fg = 0, fr = 0, dg = 0, dr = 0;
  bit          fetch_phase = 1'b1;
  bit          no_gnt = 1'b0, junk = 1'b0, run_en = 1'b0;
  int          req_cnt = 0;
  bit          rv_pend = 1'b0;
  int          rv_cnt = 0;
  logic [31:0] rv_data = '0;
  bit          granted = 1'b0, gnt_we = 1'b0, prev_wait = 1'b0;
  logic [31:0] h_addr = '0, h_wdata = '0;
  logic        h_we = 1'b0;

  // Expected cycles from FETCH entry to the retire pulse, from the handshake rules.
  function automatic int exp_latency(input logic [31:0] ins);
    int l;
    l = (fg + 1) + (fr + 1) + 1;
    if (ins[1:0] == 2'd2)      l += dg + 1;
    else if (ins[1:0] == 2'd1) l += (dg + 1) + (dr + 1) + 1;
    return l;
  endfunction

  // One clock: drive inputs at the falling edge, answer the request, sample 2ns later.
  task automatic step();
    core_t c;
    int    gd, rdl;
    @(negedge clk);
    run = run_en;
    c = decode(instr, pc);
    coreRdEn   = c.rd;    coreWrEn   = c.wr;    coreRegWr = c.regwr;
    coreRdAddr = c.addr;  coreWrAddr = c.addr;  coreWrData = c.wdata;
    corePcNxt  = c.pcnxt;
    memRvalid = 1'b0;
    memRdata  = $urandom;
    if (rv_pend) begin
      if (rv_cnt == 0) begin
        memRvalid   = 1'b1;
        memRdata    = rv_data;
        rv_pend     = 1'b0;
        fetch_phase = 1'b0;
      end else begin
        rv_cnt--;
      end
    end else if (junk && ($urandom_range(0, 3) == 0)) begin
      memRvalid = 1'b1;
    end
    #1;
    gd = fetch_phase ? fg : dg;
    rdl = fetch_phase ? fr : dr;
    memGnt  = 1'b0;
    granted = 1'b0;
    if (prev_wait && !halted) begin
      check_bit("req_hold", memReq, 1'b1);
      check_bit("we_hold", memWe, h_we);
      check("addr_hold", memAddr, h_addr);
      check("wdata_hold", memWdata, h_wdata);
    end
    if (memReq) begin
      if (!no_gnt && req_cnt >= gd) begin
        memGnt  = 1'b1;
        granted = 1'b1;
        gnt_we  = memWe;
        req_cnt = 0;
        if (memWe) mem[memAddr[9:2]] = memWdata;
        else begin
          rv_pend = 1'b1;
          rv_cnt  = rdl;
          rv_data = mem[memAddr[9:2]];
        end
      end else begin
        req_cnt++;
      end
    end else begin
      req_cnt = 0;
      if (junk && ($urandom_range(0, 3) == 0)) memGnt = 1'b1;
    end
    prev_wait = memReq && !memGnt;
    h_addr = memAddr; h_wdata = memWdata; h_we = memWe;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; run_en = 1'b0;
    memGnt = 1'b0; memRvalid = 1'b0; memRdata = '0;
    rv_pend = 1'b0; req_cnt = 0; prev_wait = 1'b0; fetch_phase = 1'b1;
    no_gnt = 1'b0; junk = 1'b0;
    inj_misalign = 1'b0; inj_both = 1'b0; inj_pc_off = '0;
    fg = 0; fr = 0; dg = 0; dr = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic exec_one(input int budget, output int lat);
    fetch_phase = 1'b1;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!retire && !halted && lat < budget);
  endtask

  task automatic clear_mem();
    for (int k = 0; k < 256; k++) mem[k] = 32'h0;
  endtask

  typedef struct {
    string       name;
    logic [31:0] ins;
    int          didx;
    logic [31:0] dpre;
    int          vfg, vfr, vdg, vdr;
    int          lat;
    logic        rw;
    logic [31:0] ld;
    logic [31:0] pc_after;
    int          cidx;
    logic [31:0] cval;
  } vec_t;

  vec_t vec [7];

  initial begin
    int          lat, elat, bad, reqs, mism;
    logic [31:0] ins, exp_pc, exp_ld;
    core_t       c;

    vec[0] = '{"alu_add",        32'h0000_0004,  1, 32'h0,         0, 0, 0, 0,  3, 1'b1, 32'h0,         32'h4,  1, 32'h0};
    vec[1] = '{"load_slow",      32'h0000_0105, 16, 32'hDEADBEEF,  0, 0, 2, 2, 10, 1'b1, 32'hDEADBEEF,  32'h4, 16, 32'hDEADBEEF};
    vec[2] = '{"store_slow",     32'h5500_0406, 64, 32'h0,         0, 0, 2, 0,  6, 1'b0, 32'h0,         32'h4, 64, 32'h55};
    vec[3] = '{"branch",         32'h0001_0003,  1, 32'h0,         0, 0, 0, 0,  3, 1'b0, 32'h0,         32'h40, 1, 32'h0};
    vec[4] = '{"store_fast",     32'hAA00_0202, 32, 32'h0,         0, 0, 0, 0,  4, 1'b0, 32'h0,         32'h4, 32, 32'hAA};
    vec[5] = '{"load_fast",      32'h0000_0085,  8, 32'h1234_5678, 0, 0, 0, 0,  6, 1'b1, 32'h1234_5678, 32'h4,  8, 32'h1234_5678};
    vec[6] = '{"alu_fetch_slow", 32'h0000_0000,  1, 32'h0,         1, 2, 0, 0,  6, 1'b0, 32'h0,         32'h4,  1, 32'h0};

    // Reset state.
    do_reset();
    #1;
    check("rst_pc", pc, RESET_PC);
    check("rst_instr", instr, 32'h0);
    check("rst_rdata", coreMemRdData, 32'h0);
    check_bit("rst_memreq", memReq, 1'b0);
    check_bit("rst_halted", halted, 1'b0);
    check_bit("rst_errs", errTimeout | errAlign, 1'b0);

    // Directed single-instruction vectors.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      clear_mem();
      mem[0] = vec[i].ins;
      mem[vec[i].didx] = vec[i].dpre;
      fg = vec[i].vfg; fr = vec[i].vfr; dg = vec[i].vdg; dr = vec[i].vdr;
      run_en = 1'b1;
      exec_one(40, lat);
      check_bit({vec[i].name, "_retire"}, retire, 1'b1);
      check({vec[i].name, "_latency"}, 32'(lat), 32'(vec[i].lat));
      check_bit({vec[i].name, "_regwr"}, regWrEn, vec[i].rw);
      check({vec[i].name, "_rdata"}, coreMemRdData, vec[i].ld);
      step();
      check({vec[i].name, "_pc"}, pc, vec[i].pc_after);
      check({vec[i].name, "_next_addr"}, memAddr, vec[i].pc_after);
      check({vec[i].name, "_mem"}, mem[vec[i].cidx], vec[i].cval);
    end

    // run=0 keeps the port idle with no timeout; run=1 requests the same cycle.
    do_reset();
    junk = 1'b1;
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (memReq || halted || errTimeout || retire) bad++;
    end
    check("idle_quiet", 32'(bad), 32'h0);
    junk = 1'b0;
    no_gnt = 1'b1;
    run_en = 1'b1;
    step();
    check_bit("run_starts", memReq, 1'b1);
    check("run_addr", memAddr, RESET_PC);

    // Grant withheld: MAX_WAIT request cycles, then HALT with errTimeout.
    reqs = 1;
    for (int k = 0; k < 400 && !halted; k++) begin
      step();
      if (memReq) reqs++;
    end
    check("timeout_req_cycles", 32'(reqs), 32'(MAX_WAIT));
    check_bit("timeout_flag", errTimeout, 1'b1);
    check_bit("timeout_halted", halted, 1'b1);
    check_bit("timeout_memreq", memReq, 1'b0);
    check_bit("timeout_no_align", errAlign, 1'b0);
    no_gnt = 1'b0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (memReq || retire || !halted || !errTimeout) bad++;
    end
    check("halt_sticky", 32'(bad), 32'h0);

    // Misaligned load address 0x102.
    do_reset();
    clear_mem();
    mem[0] = 32'h0000_0405;
    inj_misalign = 1'b1;
    run_en = 1'b1;
    exec_one(20, lat);
    check_bit("misalign_halted", halted, 1'b1);
    check_bit("misalign_flag", errAlign, 1'b1);
    check_bit("misalign_no_retire", retire, 1'b0);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (memReq || retire) bad++;
    end
    check("misalign_no_req", 32'(bad), 32'h0);
    check("misalign_pc", pc, RESET_PC);

    // Load and store requested together is illegal.
    do_reset();
    clear_mem();
    mem[0] = 32'h0000_0405;
    inj_both = 1'b1;
    run_en = 1'b1;
    exec_one(20, lat);
    check_bit("both_halted", halted, 1'b1);
    check_bit("both_flag", errAlign, 1'b1);

    // Misaligned next PC: commit happens, the following fetch halts without a request.
    do_reset();
    clear_mem();
    inj_pc_off = 32'd2;
    run_en = 1'b1;
    exec_one(20, lat);
    check_bit("pcmis_retire", retire, 1'b1);
    step();
    check("pcmis_pc", pc, 32'h6);
    check_bit("pcmis_no_req", memReq, 1'b0);
    step();
    check_bit("pcmis_halted", halted, 1'b1);
    check_bit("pcmis_flag", errAlign, 1'b1);
    do_reset();
    #1;
    check_bit("rst_clears_align", errAlign, 1'b0);
    check_bit("rst_clears_halt", halted, 1'b0);

    // Reset while waiting for load data.
    clear_mem();
    mem[0]  = 32'h0001_0003;
    mem[16] = 32'h0000_0085;
    mem[8]  = 32'hCAFE_F00D;
    run_en = 1'b1;
    exec_one(20, lat);
    dr = 6;
    fetch_phase = 1'b1;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!(granted && !gnt_we && !fetch_phase) && lat < 20);
    check_bit("dwait_reached", granted & ~gnt_we, 1'b1);
    step();
    check("dwait_pc_stable", pc, 32'h40);
    rst = 1'b1;
    #1;
    check("midrst_pc", pc, RESET_PC);
    check("midrst_instr", instr, 32'h0);
    check_bit("midrst_memreq", memReq, 1'b0);
    check_bit("midrst_flags", errTimeout | errAlign | halted, 1'b0);
    do_reset();
    run_en = 1'b1;
    exec_one(20, lat);
    check("midrst_refetch_latency", 32'(lat), 32'd3);
    check("midrst_rdata", coreMemRdData, 32'h0);

    // Random instruction stream against a transaction-level model.
    do_reset();
    for (int k = 0; k < 256; k++) begin
      mem[k] = $urandom;
      ref_mem[k] = mem[k];
    end
    junk = 1'b1;
    run_en = 1'b1;
    exp_pc = RESET_PC;
    exp_ld = 32'h0;
    for (int n = 0; n < 150; n++) begin
      fg = $urandom_range(0, 3); fr = $urandom_range(0, 3);
      dg = $urandom_range(0, 3); dr = $urandom_range(0, 3);
      ins = ref_mem[exp_pc[9:2]];
      c = decode(ins, exp_pc);
      elat = exp_latency(ins);
      if (c.rd) exp_ld = ref_mem[c.addr[9:2]];
      if (c.wr) ref_mem[c.addr[9:2]] = c.wdata;
      exec_one(60, lat);
      check_bit("rnd_retire", retire, 1'b1);
      if (!retire) break;
      check("rnd_latency", 32'(lat), 32'(elat));
      check("rnd_instr", instr, ins);
      check("rnd_pc", pc, exp_pc);
      check_bit("rnd_regwr", regWrEn, c.wr ? 1'b0 : c.regwr);
      if (c.rd) check("rnd_load_data", coreMemRdData, exp_ld);
      exp_pc = c.pcnxt;
    end
    mism = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== ref_mem[k]) mism++;
    check("rnd_mem_image", 32'(mism), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
